universal_shift_reg: RTL
========================

Name: universal_shift_reg

Overview:
- Parametrised successor to the 8-bit load/shift register: a WIDTH-bit universal shift register with parallel load and serial in/out.
- Six shift modes: logical left/right, rotate left/right, arithmetic right, hold.
- A multi-cycle "shift by N" sequencer with a start/busy/done handshake, one bit position per cycle.
- Sits between switch/key input logic and LED/display output, or feeds a serial consumer.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the shift-amount input; max request is 2^CNT_W-1 shifts.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- load_en  input  1  parallel load request (honoured only in IDLE).
- load_val  input  WIDTH  parallel load value.
- mode  input  3  shift mode, sampled on start: 0 HOLD, 1 SRL, 2 SLL, 3 ROR, 4 ROL, 5 SRA, 6/7 reserved (treated as HOLD).
- amount  input  CNT_W  number of single-bit shifts, sampled on start.
- serial_in  input  1  fill bit for SRL (enters MSB) and SLL (enters LSB); sampled on every shift edge.
- start  input  1  begin an operation (honoured only in IDLE).
- q  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted or rotated out; registered.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset, applied at any clock edge in any state, overrides everything:
  - q=0, serial_out=0, busy=0, done=0.
  - State=IDLE, latched mode/counter cleared.
  - An operation in progress is abandoned.
- FSM states: IDLE, SHIFT, DONE. busy=(state==SHIFT) and done=(state==DONE), both decoded from registered state.
- IDLE:
  - load_en=1: q<=load_val and state stays IDLE. load_en has priority over start; a start in the same cycle is dropped.
  - start=1 with amount>0: latch mode, set rem=amount, go to SHIFT; q is unchanged on this edge.
  - start=1 with amount==0: go directly to DONE; q unchanged.
- SHIFT:
  - Each edge applies one shift step using the latched mode and decrements rem.
  - When rem==1 on that edge, the state goes to DONE.
  - For a start sampled at edge 0 with amount K>0: shifts occur at edges 1..K, busy is high between edge 0 and edge K (K cycles), and done is high for the one cycle after edge K.
- DONE: unconditionally returns to IDLE on the next edge. load_en/start in DONE are ignored.
- Inputs during SHIFT/DONE: load_en, start, mode and amount are ignored. serial_in remains live and is sampled at each shift edge.
- Shift step, with n=WIDTH-1:
  - SRL: q<={serial_in,q[n:1]}, serial_out<=q[0].
  - SLL: q<={q[n-1:0],serial_in}, serial_out<=q[n].
  - ROR: q<={q[0],q[n:1]}, serial_out<=q[0].
  - ROL: q<={q[n-1:0],q[n]}, serial_out<=q[n].
  - SRA: q<={q[n],q[n:1]}, serial_out<=q[0]; serial_in ignored.
  - HOLD/reserved: q and serial_out unchanged, but the counter still runs, so busy/done timing is identical.
- amount > WIDTH is legal: rotates wrap naturally, and logical shifts keep filling from serial_in.
- serial_out changes only on shift edges and reset; a load does not alter it.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = even parity (XOR) of q.
  - parity is registered, updated on the same edge as every q update (load, shift, reset->0).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package usr_pkg holds:
  - mode encoding constants (MODE_HOLD..MODE_SRA);
  - the FSM state typedef (IDLE/SHIFT/DONE).
- Sub-module usr_step_logic: purely combinational.
  - Inputs: q, latched mode, serial_in.
  - Outputs: next q and shifted-out bit.
  - Instantiated once by universal_shift_reg, which owns the FSM, counter and registers.

Test Plan:
- Reset: load 0xA5, then assert reset for 1 cycle -> q=0x00, serial_out=0, busy=0, done=0, and state IDLE on the next cycle.
- SRL: load 0xA5, start mode=1 amount=3 serial_in=1 -> q goes 0xD2, 0xE9, 0xF4 on successive edges; busy for 3 cycles; done pulses 1 cycle; serial_out=1.
- ROL wrap: load 0x81, mode=4 amount=9 -> q=0x81 after 8 shifts and 0x03 after 9; busy for 9 cycles, then done.
- SRA: load 0x80, mode=5 amount=2, serial_in=0 -> q 0xC0 then 0xE0; serial_out=0.
- Corners:
  - amount=0 -> done the cycle after start, busy never high, q unchanged.
  - load_en=1 with start=1 in IDLE -> q=load_val, no operation.
  - start during SHIFT -> ignored.
- Reset mid-op: mode=1 amount=5 started, reset asserted on the 2nd shift cycle -> next cycle q=0, busy=0, no done pulse; a fresh start is then accepted.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for universal_shift_reg.
//   - MODE_* : shift mode encodings carried on the 3-bit mode input
//   - state_t: sequencer states (IDLE, SHIFT, DONE)
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SRL  = 3'd1;
  localparam logic [2:0] MODE_SLL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_SRA  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/usr_step_logic.sv
// Combinational single-bit shift step.
//   q         : current register contents
//   mode      : latched shift mode
//   serial_in : fill bit for SRL/SLL
//   q_next    : register contents after one step
//   out_bit   : bit shifted/rotated out this step
//   out_vld   : 1 when the step moves a bit out (0 for HOLD/reserved modes,
//               so the caller keeps serial_out unchanged)
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit,
  output logic             out_vld
);
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    out_vld = 1'b0;
    case (mode)
      MODE_SRL: begin
        q_next  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
        out_vld = 1'b1;
      end
      MODE_SLL: begin
        q_next  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
        out_vld = 1'b1;
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
        out_vld = 1'b1;
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
        out_vld = 1'b1;
      end
      MODE_SRA: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
        out_vld = 1'b1;
      end
      default: ; // HOLD and reserved encodings leave everything as is
    endcase
  end
endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with parallel load, serial in/out and
// a multi-cycle "shift by N" sequencer (one bit position per clock).
//   clk, reset  : clock, synchronous active-high reset
//   load_en/val : parallel load (IDLE only, wins over start)
//   mode/amount : operation, sampled on start
//   serial_in   : fill bit for SRL/SLL, sampled on every shift edge
//   start       : begin an operation (IDLE only)
//   q           : register contents
//   serial_out  : last bit shifted/rotated out (registered)
//   busy / done : in SHIFT / one-cycle completion pulse
// Optional: define USR_PARITY_EN to add a registered even-parity output
// `parity` tracking q.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);
  state_t           state;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] q_next;
  logic             out_bit;
  logic             out_vld;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .q        (q),
    .mode     (mode_q),
    .serial_in(serial_in),
    .q_next   (q_next),
    .out_bit  (out_bit),
    .out_vld  (out_vld)
  );

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      serial_out <= 1'b0;
      mode_q     <= MODE_HOLD;
      rem        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            q <= load_val;
          end else if (start) begin
            mode_q <= mode;
            rem    <= amount;
            state  <= (amount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          q   <= q_next;
          rem <= rem - 1'b1;
          if (out_vld) serial_out <= out_bit;
          if (rem == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USR_PARITY_EN
  // Parity follows every q write so it always matches the registered q.
  always_ff @(posedge clk) begin
    if (reset)                        parity <= 1'b0;
    else if (state == IDLE && load_en) parity <= ^load_val;
    else if (state == SHIFT)           parity <= ^q_next;
  end
`endif
endmodule
